// File: rtl/spram_bus_bridge.sv
// spram_bus_bridge
//   Bridges a 32-bit request/acknowledge CPU bus onto one 16K x 16 SPRAM.
//   Each word access is split into two halfword accesses: low half, then
//   high half. Requests outside the 32 KB window at BASE_ADDR are
//   acknowledged at once with m_err set and never touch the RAM.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   m_req, m_wr         CPU request (held until m_ack), 1 = write
//   m_addr, m_wdata     byte address (bits [1:0] ignored), write data
//   m_be                write byte enables
//   m_rdata, m_ack      read data (held between acks), one-cycle ack pulse
//   m_err               out-of-window flag, valid with m_ack
//   ram_addr            SPRAM halfword address
//   ram_wdata           SPRAM write data
//   ram_maskwren        SPRAM nibble write mask
//   ram_wren            SPRAM write enable
//   ram_rdata           SPRAM read data, one cycle after its address
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for m_req; request fields latched on acceptance
// LO    | low halfword access (write, or read address issued)
// HI    | high halfword access; low read data captured
// RD2   | high read data captured, RAM idle
// ACK   | m_ack pulse (m_err on out-of-window), back to IDLE

module spram_bus_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_req,
    input  logic        m_wr,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_be,
    output logic [31:0] m_rdata,
    output logic        m_ack,
    output logic        m_err,
    output logic [13:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic [3:0]  ram_maskwren,
    output logic        ram_wren,
    input  logic [15:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_RD2,
        S_ACK
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [12:0] word_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        wr_q;

    logic        in_window;
    logic        accept;

    // Word-aligned access: the byte offset bits carry no information.
    logic [1:0]  unused_addr_bits;
    assign unused_addr_bits = m_addr[1:0];

    assign in_window = (m_addr[31:15] == BASE_ADDR[31:15]);
    assign accept    = (state_q == S_IDLE) && m_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            m_ack   <= 1'b0;
            m_err   <= 1'b0;
            m_rdata <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                word_q  <= m_addr[14:2];
                wdata_q <= m_wdata;
                be_q    <= m_be;
                wr_q    <= m_wr;
            end

            // Ack/err are registered off the next state so they line up
            // with the cycle the FSM spends in ACK.
            m_ack <= (state_d == S_ACK);
            m_err <= accept && !in_window;

            if (accept && !in_window) begin
                m_rdata <= '0;
            end else if (state_q == S_HI && !wr_q) begin
                // Data for the LO address issued last cycle.
                m_rdata[15:0] <= ram_rdata;
            end else if (state_q == S_RD2) begin
                m_rdata[31:16] <= ram_rdata;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ram_addr     = {word_q, 1'b0};
        ram_wdata    = wdata_q[15:0];
        ram_maskwren = 4'h0;
        ram_wren     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (m_req) begin
                    state_d = in_window ? S_LO : S_ACK;
                end
            end
            S_LO: begin
                ram_maskwren = {be_q[1], be_q[1], be_q[0], be_q[0]};
                ram_wren     = wr_q;
                state_d      = S_HI;
            end
            S_HI: begin
                ram_addr     = {word_q, 1'b1};
                ram_wdata    = wdata_q[31:16];
                ram_maskwren = {be_q[3], be_q[3], be_q[2], be_q[2]};
                ram_wren     = wr_q;
                state_d      = wr_q ? S_ACK : S_RD2;
            end
            S_RD2: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spram_bus_bridge.sv
// tb_spram_bus_bridge
//   Directed bench for spram_bus_bridge with a behavioural 16K x 16 SPRAM
//   (nibble write mask, registered read data).

module tb_spram_bus_bridge;

    logic        clk;
    logic        reset;
    logic        m_req;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        m_err;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [3:0]  ram_maskwren;
    logic        ram_wren;
    logic [15:0] ram_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int wren_cnt = 0;

    logic [15:0] mem [0:16383];

    logic [13:0] tr_addr  [0:8];
    logic [15:0] tr_wdata [0:8];
    logic [3:0]  tr_mask  [0:8];
    logic [31:0] ack_rdata;
    logic        ack_err;

    spram_bus_bridge #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_be         (m_be),
        .m_rdata      (m_rdata),
        .m_ack        (m_ack),
        .m_err        (m_err),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_maskwren (ram_maskwren),
        .ram_wren     (ram_wren),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        ram_rdata = 16'h0000;
    end

    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_wren) begin
            for (int n = 0; n < 4; n++) begin
                if (ram_maskwren[n]) mem[ram_addr][n*4 +: 4] = ram_wdata[n*4 +: 4];
            end
        end
    end

    always @(negedge clk) begin
        if (ram_wren) wren_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request and records the RAM-side signals per cycle.
    // lat is the cycle (counted from the sample edge) at which m_ack was seen.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input bit hold, output int lat);
        @(negedge clk);
        m_req   = 1'b1;
        m_wr    = wr;
        m_addr  = addr;
        m_wdata = wd;
        m_be    = be;
        @(posedge clk);
        #1;
        if (!hold) begin
            // Post-sample changes must not leak into the transaction.
            m_addr  = addr ^ 32'h0000_1FF0;
            m_wdata = ~wd;
            m_be    = ~be;
        end
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            tr_addr[c]  = ram_addr;
            tr_wdata[c] = ram_wdata;
            tr_mask[c]  = ram_maskwren;
            if (m_ack) begin
                lat       = c;
                ack_rdata = m_rdata;
                ack_err   = m_err;
                if (!hold) m_req = 1'b0;
                break;
            end
        end
        if (lat < 0) begin
            chk("ack_timeout", 32'd0, 32'd1);
            m_req = 1'b0;
        end
    endtask

    // Counts cycles from the current ack to the next one with m_req held.
    task automatic next_ack(output int lat);
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk("held_single_pulse", {31'd0, m_ack}, 32'd0);
            if (m_ack) begin
                lat       = c;
                ack_rdata = m_rdata;
                ack_err   = m_err;
                m_req     = 1'b0;
                break;
            end
        end
        if (lat < 0) begin
            chk("held_ack_timeout", 32'd0, 32'd1);
            m_req = 1'b0;
        end
    endtask

    int lat;
    int wc;

    initial begin
        reset   = 1'b1;
        m_req   = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ack",   {31'd0, m_ack},    32'd0);
        chk("rst_err",   {31'd0, m_err},    32'd0);
        chk("rst_rdata", m_rdata,           32'd0);
        chk("rst_wren",  {31'd0, ram_wren}, 32'd0);
        chk("rst_mask",  {28'd0, ram_maskwren}, 32'd0);
        chk("rst_raddr", {18'd0, ram_addr}, 32'd0);
        chk("rst_wdata", {16'd0, ram_wdata}, 32'd0);

        // Full word write then read.
        wc = wren_cnt;
        run_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, lat);
        chk("wr_lat",     lat, 32'd3);
        chk("wr_err",     {31'd0, ack_err}, 32'd0);
        chk("wr_addr_lo", {18'd0, tr_addr[1]}, 32'h080);
        chk("wr_addr_hi", {18'd0, tr_addr[2]}, 32'h081);
        chk("wr_mask_lo", {28'd0, tr_mask[1]}, 32'hF);
        chk("wr_mask_hi", {28'd0, tr_mask[2]}, 32'hF);
        chk("wr_data_lo", {16'd0, tr_wdata[1]}, 32'hBEEF);
        chk("wr_data_hi", {16'd0, tr_wdata[2]}, 32'hDEAD);
        chk("wr_pulses",  wren_cnt - wc, 32'd2);
        chk("wr_keeps_rdata", m_rdata, 32'd0);

        wc = wren_cnt;
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, lat);
        chk("rd_lat",    lat, 32'd4);
        chk("rd_data",   ack_rdata, 32'hDEAD_BEEF);
        chk("rd_err",    {31'd0, ack_err}, 32'd0);
        chk("rd_no_wr",  wren_cnt - wc, 32'd0);

        // Single byte write into the high half.
        run_txn(1'b1, 32'h0000_0100, 32'h1122_3344, 4'b0100, 1'b0, lat);
        chk("bw_lat",     lat, 32'd3);
        chk("bw_mask_lo", {28'd0, tr_mask[1]}, 32'h0);
        chk("bw_mask_hi", {28'd0, tr_mask[2]}, 32'h3);
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, lat);
        chk("bw_rd_data", ack_rdata, 32'hDE22_BEEF);

        // Write with no byte enables completes but changes nothing.
        run_txn(1'b1, 32'h0000_0100, 32'h5555_AAAA, 4'h0, 1'b0, lat);
        chk("be0_lat",     lat, 32'd3);
        chk("be0_mask_lo", {28'd0, tr_mask[1]}, 32'h0);
        chk("be0_mask_hi", {28'd0, tr_mask[2]}, 32'h0);
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, lat);
        chk("be0_rd_data", ack_rdata, 32'hDE22_BEEF);

        // Out of window.
        wc = wren_cnt;
        run_txn(1'b0, 32'h0000_8000, 32'h0, 4'h0, 1'b0, lat);
        chk("oor_rd_lat",   lat, 32'd1);
        chk("oor_rd_err",   {31'd0, ack_err}, 32'd1);
        chk("oor_rd_rdata", ack_rdata, 32'd0);
        run_txn(1'b1, 32'h0000_8004, 32'hFFFF_FFFF, 4'hF, 1'b0, lat);
        chk("oor_wr_lat",   lat, 32'd1);
        chk("oor_wr_err",   {31'd0, ack_err}, 32'd1);
        chk("oor_no_wr",    wren_cnt - wc, 32'd0);
        run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b0, lat);
        chk("oor_alias_clean", ack_rdata, 32'd0);
        chk("ok_after_oor_err", {31'd0, ack_err}, 32'd0);

        // Top of the window.
        run_txn(1'b1, 32'h0000_7FFC, 32'hCAFE_F00D, 4'hF, 1'b0, lat);
        chk("top_addr_lo", {18'd0, tr_addr[1]}, 32'h3FFE);
        chk("top_addr_hi", {18'd0, tr_addr[2]}, 32'h3FFF);
        chk("top_wr_keeps_rdata", m_rdata, 32'd0);
        run_txn(1'b0, 32'h0000_7FFF, 32'h0, 4'h0, 1'b0, lat);
        chk("top_rd_data", ack_rdata, 32'hCAFE_F00D);

        // Held request: duplicate transaction starts at ack+1.
        run_txn(1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 1'b1, lat);
        chk("held_wr_lat1", lat, 32'd3);
        next_ack(lat);
        chk("held_wr_lat2", lat, 32'd4);
        run_txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b1, lat);
        chk("held_rd_lat1", lat, 32'd4);
        chk("held_rd_data1", ack_rdata, 32'h1234_5678);
        next_ack(lat);
        chk("held_rd_lat2", lat, 32'd5);
        chk("held_rd_data2", ack_rdata, 32'h1234_5678);
        @(negedge clk);
        chk("held_after_drop", {31'd0, m_ack}, 32'd0);

        // Reset while in HI of a read.
        @(negedge clk);
        m_req  = 1'b1;
        m_wr   = 1'b0;
        m_addr = 32'h0000_0100;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_ack",   {31'd0, m_ack}, 32'd0);
        chk("mid_rst_rdata", m_rdata, 32'd0);
        chk("mid_rst_wren",  {31'd0, ram_wren}, 32'd0);
        chk("mid_rst_mask",  {28'd0, ram_maskwren}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_no_ack", {31'd0, m_ack}, 32'd0);
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, lat);
        chk("post_rst_lat",  lat, 32'd4);
        chk("post_rst_data", ack_rdata, 32'hDE22_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
